// File: rtl/mem_lsu_master.sv
// mem_lsu_master
// Initiator side of the split cmd/read/write memory interface. It takes one
// load/store request at a time from the core's load/store stage and turns it
// into a single memory transaction. The transaction carries a word-aligned
// address, byte strobes and lane-replicated write data. For loads, the
// returned word is shifted, the addressed byte or half is extracted, and the
// result is sign- or zero-extended. Exactly one response is returned per
// accepted request.
//
// Optional feature: define MEM_LSU_MASTER_TIMEOUT_EN to enable a read-wait
// watchdog. After p_TIMEOUT_CYCLES cycles in RWAIT without read data, the
// request completes with resp_err = 1.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-low reset
//   req_valid/req_ready      core request handshake
//   req_wr, req_addr, req_size, req_unsigned, req_wdata   request fields
//   resp_valid, resp_rdata, resp_err                      one-cycle response
//   mem_valid/mem_ready, mem_addr, mem_cmd, mem_size      command channel
//   mem_r_valid/mem_r_ready, mem_r_data, mem_r_resp       read data channel
//   mem_w_valid/mem_w_ready, mem_w_strb, mem_w_data, mem_w_resp  write channel
module mem_lsu_master #(
    parameter int p_ADDR_BITS      = 32,
    parameter int p_DATA_BITS      = 32,
    parameter int p_STRB_BITS      = p_DATA_BITS / 8,
    parameter int p_TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_wr,
    input  logic [p_ADDR_BITS-1:0] req_addr,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [p_DATA_BITS-1:0] req_wdata,
    output logic                   resp_valid,
    output logic [p_DATA_BITS-1:0] resp_rdata,
    output logic                   resp_err,
    output logic [p_ADDR_BITS-1:0] mem_addr,
    output logic                   mem_cmd,
    output logic [1:0]             mem_size,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic                   mem_r_ready,
    input  logic                   mem_r_valid,
    input  logic [p_DATA_BITS-1:0] mem_r_data,
    input  logic                   mem_r_resp,
    output logic                   mem_w_valid,
    input  logic                   mem_w_ready,
    output logic [p_STRB_BITS-1:0] mem_w_strb,
    output logic [p_DATA_BITS-1:0] mem_w_data,
    input  logic                   mem_w_resp
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CMD   = 2'd1;
    localparam logic [1:0] ST_RWAIT = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [1:0]             state_reg, state_next;
    logic [p_ADDR_BITS-1:2] addr_hi_reg;
    logic [1:0]             offset_reg;
    logic [1:0]             size_reg;
    logic                   wr_reg;
    logic                   unsigned_reg;
    logic [p_STRB_BITS-1:0] strb_reg, strb_next;
    logic [p_DATA_BITS-1:0] wdata_reg, wdata_next;
    logic [p_DATA_BITS-1:0] rdata_reg, rdata_ext;
    logic [p_DATA_BITS-1:0] rd_shifted;
    logic                   err_reg;
    logic                   accept;
    logic                   illegal;
    logic                   cmd_done;
    logic                   timeout_hit;

    // The response channel bits from the memory carry no information we act on.
    logic unused_resp;
    assign unused_resp = mem_r_resp ^ mem_w_resp;

    assign accept  = req_valid && (state_reg == ST_IDLE);
    assign illegal = (req_size == 2'd3)
                  || ((req_size == SZ_HALF) && req_addr[0])
                  || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

    // A write needs both the command and the write-data beat to be taken in
    // the same cycle, because mem_w_valid rises and falls with mem_valid.
    assign cmd_done = mem_ready && (!wr_reg || mem_w_ready);

    always_comb begin
        strb_next = '0;
        case (req_size)
            SZ_BYTE: strb_next = {{(p_STRB_BITS-1){1'b0}}, 1'b1}  << req_addr[1:0];
            SZ_HALF: strb_next = {{(p_STRB_BITS-2){1'b0}}, 2'b11} << req_addr[1:0];
            SZ_WORD: strb_next = '1;
            default: strb_next = '0;
        endcase
    end

    // Lane replication: each byte lane picks the store byte that would land
    // there if the data were placed at any legal offset for its size.
    generate
        for (genvar gi = 0; gi < p_STRB_BITS; gi++) begin : g_lane
            always_comb begin
                case (req_size)
                    SZ_BYTE: wdata_next[8*gi +: 8] = req_wdata[7:0];
                    SZ_HALF: wdata_next[8*gi +: 8] = req_wdata[8*(gi%2) +: 8];
                    default: wdata_next[8*gi +: 8] = req_wdata[8*gi +: 8];
                endcase
            end
        end
    endgenerate

    assign rd_shifted = mem_r_data >> {offset_reg, 3'b000};

    always_comb begin
        case (size_reg)
            SZ_BYTE: rdata_ext = {{(p_DATA_BITS-8){!unsigned_reg && rd_shifted[7]}},
                                  rd_shifted[7:0]};
            SZ_HALF: rdata_ext = {{(p_DATA_BITS-16){!unsigned_reg && rd_shifted[15]}},
                                  rd_shifted[15:0]};
            default: rdata_ext = rd_shifted;
        endcase
    end

`ifdef MEM_LSU_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(p_TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(p_TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_reg;

    // Held at zero while the command is outstanding, so every RWAIT entry
    // starts counting from zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == ST_CMD) begin
            tmo_cnt_reg <= '0;
        end else if ((state_reg == ST_RWAIT) && !mem_r_valid) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    assign timeout_hit = (tmo_cnt_reg == TMO_LAST);
`else
    localparam int unused_timeout_cycles = p_TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (req_valid) state_next = illegal ? ST_RESP : ST_CMD;
            ST_CMD:   if (cmd_done) state_next = wr_reg ? ST_RESP : ST_RWAIT;
            ST_RWAIT: if (mem_r_valid || timeout_hit) state_next = ST_RESP;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            addr_hi_reg  <= '0;
            offset_reg   <= '0;
            size_reg     <= '0;
            wr_reg       <= 1'b0;
            unsigned_reg <= 1'b0;
            strb_reg     <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_hi_reg  <= req_addr[p_ADDR_BITS-1:2];
                offset_reg   <= req_addr[1:0];
                size_reg     <= req_size;
                wr_reg       <= req_wr;
                unsigned_reg <= req_unsigned;
                strb_reg     <= strb_next;
                wdata_reg    <= wdata_next;
                rdata_reg    <= '0;
                err_reg      <= illegal;
            end
            if (state_reg == ST_RWAIT) begin
                if (mem_r_valid) begin
                    rdata_reg <= rdata_ext;
                end else if (timeout_hit) begin
                    rdata_reg <= '0;
                    err_reg   <= 1'b1;
                end
            end
        end
    end

    assign req_ready   = (state_reg == ST_IDLE);
    assign mem_valid   = (state_reg == ST_CMD);
    assign mem_w_valid = (state_reg == ST_CMD) && wr_reg;
    assign mem_r_ready = (state_reg == ST_RWAIT);
    assign resp_valid  = (state_reg == ST_RESP);
    assign resp_rdata  = rdata_reg;
    assign resp_err    = err_reg;
    assign mem_addr    = {addr_hi_reg, 2'b00};
    assign mem_cmd     = wr_reg;
    assign mem_size    = size_reg;
    assign mem_w_strb  = strb_reg;
    assign mem_w_data  = wdata_reg;

endmodule

// File: tb/tb_mem_lsu_master.sv
// Testbench for mem_lsu_master: directed load/store vectors with a response
// scoreboard, a memory responder that also checks the command channel, and
// reset / backpressure / optional timeout scenarios.
module tb_mem_lsu_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic        mem_cmd;
    logic [1:0]  mem_size;
    logic        mem_valid, mem_ready, mem_r_ready, mem_r_valid, mem_r_resp;
    logic [31:0] mem_r_data;
    logic        mem_w_valid, mem_w_ready, mem_w_resp;
    logic [3:0]  mem_w_strb;
    logic [31:0] mem_w_data;

    always #5 clk = ~clk;

    mem_lsu_master #(
        .p_ADDR_BITS(32), .p_DATA_BITS(32), .p_STRB_BITS(4), .p_TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_cmd(mem_cmd), .mem_size(mem_size),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_r_ready(mem_r_ready), .mem_r_valid(mem_r_valid),
        .mem_r_data(mem_r_data), .mem_r_resp(mem_r_resp),
        .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready),
        .mem_w_strb(mem_w_strb), .mem_w_data(mem_w_data), .mem_w_resp(mem_w_resp)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
        string       name;
    } exp_t;
    exp_t sb_q[$];

    // Memory responder controls and expected command fields.
    int          ready_wait = 0;
    int          rv_wait    = 0;
    bit          never_rv   = 1'b0;
    bit          cmd_expected = 1'b0;
    int          hs_count   = 0;
    logic [31:0] mem_word   = '0;
    logic [31:0] ex_addr, ex_wdata;
    logic [3:0]  ex_strb;
    logic [1:0]  ex_size;
    logic        ex_cmd;

    assign mem_r_data = mem_word;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check32({tag, "_req_ready"},   32'(req_ready),   32'd1);
        check32({tag, "_resp_valid"},  32'(resp_valid),  32'd0);
        check32({tag, "_resp_err"},    32'(resp_err),    32'd0);
        check32({tag, "_resp_rdata"},  resp_rdata,       32'd0);
        check32({tag, "_mem_valid"},   32'(mem_valid),   32'd0);
        check32({tag, "_mem_w_valid"}, 32'(mem_w_valid), 32'd0);
        check32({tag, "_mem_r_ready"}, 32'(mem_r_ready), 32'd0);
        check32({tag, "_mem_addr"},    mem_addr,         32'd0);
        check32({tag, "_mem_w_data"},  mem_w_data,       32'd0);
        check32({tag, "_mem_w_strb"},  32'(mem_w_strb),  32'd0);
        check32({tag, "_mem_size"},    32'(mem_size),    32'd0);
        check32({tag, "_mem_cmd"},     32'(mem_cmd),     32'd0);
    endtask

    // Memory model: checks the command fields on every cycle mem_valid is
    // high (which also proves they hold still under backpressure), and drives
    // mem_ready / mem_r_valid for the next edge.
    initial begin
        mem_ready = 1'b0; mem_w_ready = 1'b0; mem_r_valid = 1'b0;
        mem_r_resp = 1'b0; mem_w_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_valid) begin
                if (!cmd_expected) begin
                    checks++; errors++;
                    $display("FAIL mem_valid_on_error actual=1 required=0");
                end else begin
                    check32("cmd_addr",    mem_addr,         ex_addr);
                    check32("cmd_cmd",     32'(mem_cmd),     32'(ex_cmd));
                    check32("cmd_size",    32'(mem_size),    32'(ex_size));
                    check32("cmd_w_valid", 32'(mem_w_valid), 32'(ex_cmd));
                    if (ex_cmd) begin
                        check32("cmd_w_strb", 32'(mem_w_strb), 32'(ex_strb));
                        check32("cmd_w_data", mem_w_data,      ex_wdata);
                    end
                end
                if (ready_wait > 0) begin
                    mem_ready = 1'b0; mem_w_ready = 1'b0; ready_wait--;
                end else begin
                    mem_ready = 1'b1; mem_w_ready = 1'b1; hs_count++;
                end
            end else begin
                mem_ready = 1'b0; mem_w_ready = 1'b0;
            end
            if (mem_r_ready && !never_rv) begin
                if (rv_wait > 0) begin
                    mem_r_valid = 1'b0; rv_wait--;
                end else begin
                    mem_r_valid = 1'b1;
                end
            end else begin
                mem_r_valid = 1'b0;
            end
        end
    end

    // Response monitor: pops the scoreboard whenever the DUT responds.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp actual=resp_valid required=none");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check32({e.name, "_err"},   32'(resp_err), 32'(e.err));
                    check32({e.name, "_rdata"}, resp_rdata,    e.rdata);
                    check32({e.name, "_cycle"}, 32'(cyc),      32'(e.cyc));
                    $display("txn %s: err=%0d rdata=%h cycle=%0d",
                             e.name, resp_err, resp_rdata, cyc);
                end
            end
        end
    end

    // lat: cycles from the accepting edge to the response cycle (T+lat).
    task automatic issue(input string name, input bit wr, input logic [31:0] addr,
                         input logic [1:0] size, input bit uns, input logic [31:0] wdata,
                         input logic [31:0] mword, input bit exp_err,
                         input logic [31:0] exp_rdata, input int lat,
                         input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                         input int exp_hs, input int rw, input int rvw, input bit wait_resp);
        int n;
        @(negedge clk);
        cmd_expected = !exp_err;
        ex_addr  = {addr[31:2], 2'b00};
        ex_cmd   = wr;
        ex_size  = size;
        ex_strb  = exp_strb;
        ex_wdata = exp_wd;
        hs_count = 0;
        ready_wait = rw;
        rv_wait  = rvw;
        mem_word = mword;
        req_wr = wr; req_addr = addr; req_size = size; req_unsigned = uns;
        req_wdata = wdata; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL %s_accept actual=not_accepted required=accepted", name);
            req_valid = 1'b0;
            return;
        end
        if (wait_resp) begin
            exp_t e;
            e.err = exp_err; e.rdata = exp_rdata; e.cyc = cyc + lat; e.name = name;
            sb_q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
        if (wait_resp) begin
            #1;
            n = 0;
            while (sb_q.size() != 0 && n < 100) begin
                @(negedge clk);
                #1;
                n++;
            end
            if (sb_q.size() != 0) begin
                checks++; errors++;
                $display("FAIL %s_resp actual=no_response required=response", name);
                sb_q.delete();
            end
            check32({name, "_handshakes"}, 32'(hs_count), 32'(exp_hs));
            @(negedge clk);
            check32({name, "_ready_after"}, 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_size = '0;
        req_unsigned = 1'b0; req_wdata = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst0");
        rst = 1'b1;

        //     name           wr addr     sz u wdata         mem_word      er exp_rdata     lat strb     exp_wdata     hs rw rv wait
        issue("st_b102",      1, 'h102, 0, 0, 'h123456AB, 'h0,         0, 'h0,         2, 4'b0100, 'hABABABAB, 1, 0, 0, 1);
        issue("ld_h102s",     0, 'h102, 1, 0, 'h0,        'h87654321,  0, 'hFFFF8765,  3, 4'b0,    'h0,        1, 0, 0, 1);
        issue("ld_h102u",     0, 'h102, 1, 1, 'h0,        'h87654321,  0, 'h00008765,  3, 4'b0,    'h0,        1, 0, 0, 1);
        issue("ld_b103s",     0, 'h103, 0, 0, 'h0,        'h87654321,  0, 'hFFFFFF87,  3, 4'b0,    'h0,        1, 0, 0, 1);
        issue("ld_b101u",     0, 'h101, 0, 1, 'h0,        'h87654321,  0, 'h00000043,  3, 4'b0,    'h0,        1, 0, 0, 1);
        issue("ld_b102s",     0, 'h102, 0, 0, 'h0,        'h00F00000,  0, 'hFFFFFFF0,  3, 4'b0,    'h0,        1, 0, 0, 1);
        issue("ld_w104",      0, 'h104, 2, 0, 'h0,        'h87654321,  0, 'h87654321,  3, 4'b0,    'h0,        1, 0, 0, 1);
        issue("st_h202",      1, 'h202, 1, 0, 'h0000BEEF, 'h0,         0, 'h0,         2, 4'b1100, 'hBEEFBEEF, 1, 0, 0, 1);
        issue("ld_w101_mis",  0, 'h101, 2, 0, 'h0,        'h0,         1, 'h0,         1, 4'b0,    'h0,        0, 0, 0, 1);
        issue("ld_sz3",       0, 'h100, 3, 0, 'h0,        'h0,         1, 'h0,         1, 4'b0,    'h0,        0, 0, 0, 1);
        issue("st_h103_mis",  1, 'h103, 1, 0, 'h1234,     'h0,         1, 'h0,         1, 4'b0,    'h0,        0, 0, 0, 1);
        issue("st_w200_bp",   1, 'h200, 2, 0, 'hDEADBEEF, 'h0,         0, 'h0,         5, 4'hF,    'hDEADBEEF, 1, 3, 0, 1);
        issue("ld_h100_rvd",  0, 'h100, 1, 1, 'h0,        'h87654321,  0, 'h00004321,  5, 4'b0,    'h0,        1, 0, 2, 1);

        // Reset while waiting for read data: the load must vanish silently.
        never_rv = 1'b1;
        issue("ld_rst",       0, 'h300, 2, 0, 'h0,        'h11223344,  0, 'h0,         3, 4'b0,    'h0,        1, 0, 0, 0);
        @(negedge clk);
        check32("rst_in_rwait", 32'(mem_r_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_reset_vals("rst1");
        never_rv = 1'b0;
        repeat (3) @(negedge clk);
        issue("st_b003",      1, 'h003, 0, 0, 'h0000005A, 'h0,         0, 'h0,         2, 4'b1000, 'h5A5A5A5A, 1, 0, 0, 1);

`ifdef MEM_LSU_MASTER_TIMEOUT_EN
        never_rv = 1'b1;
        issue("ld_tmo",       0, 'h400, 2, 0, 'h0,        'hCAFEF00D,  1, 'h0,        10, 4'b0,    'h0,        1, 0, 0, 1);
        never_rv = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_lsu_master.md
Name: mem_lsu_master

Overview:
- Initiator side of the split cmd/read/write memory interface.
- Sits between the core's load/store stage and the dmem port of the memory model or RAM controller.
- Converts single load/store requests (byte/half/word, signed/unsigned) into one interface transaction: word-aligned address, byte strobes, lane-replicated write data.
- Extracts and extends the read data, then returns one response per request.

Parameters:
- p_ADDR_BITS, 32, address width.
- p_DATA_BITS, 32, data width; only 32 is supported.
- p_STRB_BITS, p_DATA_BITS/8, strobe width.
- p_TIMEOUT_CYCLES, 256, read-wait watchdog limit; used only with MEM_LSU_MASTER_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  core request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_wr  in  1  1 = store, 0 = load.
- req_addr  in  p_ADDR_BITS  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  zero-extend load data when 1, sign-extend when 0.
- req_wdata  in  p_DATA_BITS  store data, LSB-justified.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  p_DATA_BITS  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, illegal size, or timeout.
- mem_addr  out  p_ADDR_BITS  {addr[31:2], 2'b00}.
- mem_cmd  out  1  0 = read, 1 = write.
- mem_size  out  2  registered req_size.
- mem_valid  out  1  command valid.
- mem_ready  in  1  command accepted.
- mem_r_ready  out  1  read data ready.
- mem_r_valid  in  1  read data valid.
- mem_r_data  in  p_DATA_BITS  read word.
- mem_r_resp  in  1  ignored.
- mem_w_valid  out  1  write data valid; asserted together with mem_valid.
- mem_w_ready  in  1  write data ready.
- mem_w_strb  out  p_STRB_BITS  byte strobes.
- mem_w_data  out  p_DATA_BITS  lane-replicated write data.
- mem_w_resp  in  1  ignored.

Behaviour:
- Reset (rst == 0 at a clk edge):
  - State goes to IDLE.
  - Outputs: req_ready = 1 (reflects IDLE); resp_valid, resp_err, mem_valid, mem_w_valid, mem_r_ready = 0; resp_rdata, mem_addr, mem_w_data, mem_w_strb, mem_size, mem_cmd = 0.
  - Reset mid-transaction abandons it; no response is produced.
- FSM states: IDLE, CMD, RWAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On accept, register address, size, write flag, unsigned flag, strobes and write data.
  - Legality check: size 3 is illegal; half with addr[0] set is misaligned; word with addr[1:0] != 0 is misaligned.
  - Illegal or misaligned request: go to RESP with err = 1; no mem_valid is ever driven.
  - Legal request: go to CMD.
- CMD:
  - mem_valid = 1; mem_w_valid = mem_cmd.
  - All mem_* command and write outputs stay stable until mem_valid && mem_ready (and for writes also mem_w_ready).
  - On that handshake: write goes to RESP; read goes to RWAIT.
- RWAIT:
  - mem_r_ready = 1.
  - On mem_r_valid, capture and extend the data, then go to RESP.
  - mem_r_valid outside RWAIT is ignored.
- RESP:
  - resp_valid = 1 for exactly one cycle, then IDLE.
  - req_ready = 0 in CMD, RWAIT and RESP, so at most one transaction is outstanding.
- Latency with a zero-wait memory, request accepted at edge T:
  - Store: mem_valid in T+1, resp_valid in T+2.
  - Load: mem_valid in T+1, mem_r_valid in T+2, resp_valid in T+3.
  - Error: resp_valid in T+1.
- Strobes and write data (o = addr[1:0]):
  - byte: strb = 4'b0001 << o; data = {4{wdata[7:0]}}.
  - half: strb = 4'b0011 << o; data = {2{wdata[15:0]}}.
  - word: strb = 4'hF; data = wdata.
- Read extraction:
  - shifted = mem_r_data >> (8*o).
  - byte: bits [7:0], extended from bit 7.
  - half: bits [15:0], extended from bit 15.
  - word: passed through unchanged.
- Back-to-back requests: the next request is accepted the cycle after RESP (IDLE); sustained throughput is 1 request per 3 cycles (store) or 4 cycles (load).

Optional Feature:
- MEM_LSU_MASTER_TIMEOUT_EN defined:
  - A counter clears on entry to RWAIT and increments each RWAIT cycle without mem_r_valid.
  - When it reaches p_TIMEOUT_CYCLES-1, go to RESP with resp_err = 1, resp_rdata = 0, mem_r_ready dropped.
  - A late mem_r_valid is then ignored.
- Not defined: no counter; RWAIT waits indefinitely.

Test Plan:
- Store byte: addr 0x102, wdata 0x123456AB, zero-wait memory -> mem_w_strb = 4'b0100, mem_w_data = 0xABABABAB, mem_addr = 0x100, resp_valid at T+2 with resp_err = 0.
- Load half signed: addr 0x102, memory word 0x87654321 -> resp_rdata = 0xFFFF8765; the same load with req_unsigned = 1 -> 0x00008765; resp_valid at T+3.
- Misaligned word load at 0x101, then size 3 at 0x100 -> each returns resp_err = 1 at T+1, mem_valid never asserts, req_ready returns to 1 the following cycle.
- Backpressure:
  - mem_ready held low 3 cycles on a word store of 0xDEADBEEF to 0x200 -> mem_valid, mem_w_valid, mem_addr = 0x200, strb = 0xF all held stable.
  - Exactly one write handshake occurs.
  - mem_r_valid delayed 2 cycles on a load -> response data is correct.
- Reset: rst low for one edge while in RWAIT -> next cycle all outputs at reset values, no resp_valid; a new request afterwards completes normally.
- Timeout (macro defined, p_TIMEOUT_CYCLES = 8): memory never asserts r_valid -> resp_valid with resp_err = 1 and resp_rdata = 0 after 8 RWAIT cycles.
